// File: rtl/packet_buffer_reader_pkg.sv
// packet_buffer_reader_pkg: slot states and pointer-width helper shared by the reader and its arbiter.
package packet_buffer_reader_pkg;

   typedef enum logic [1:0] {EMPTY, PENDING, FULL} slot_t;

   // bits needed to hold v; zero for v == 0
   function automatic int clogb2(input int v);
      int r;
      r = 0;
      for (int x = v; x > 0; x = x >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/packet_buffer_reader_arb.sv
// rr_arbiter_N: round-robin one-hot grant; search starts after the last granted index.
module rr_arbiter_N
   import packet_buffer_reader_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [SIZE-1:0] request,
   input  logic            update,
   output logic [SIZE-1:0] grant
);

   localparam int LOGN = clogb2(SIZE - 1);
   localparam int PW   = LOGN < 1 ? 1 : LOGN;

   logic [PW-1:0] ptr, idx;

   // walk offsets from farthest to nearest so the nearest request wins
   always_comb begin
      grant = '0;
      idx   = ptr;
      for (int k = SIZE; k >= 1; k--) begin
         if (request[(int'(ptr) + k) % SIZE]) begin
            grant = SIZE'(1) << ((int'(ptr) + k) % SIZE);
            idx   = PW'((int'(ptr) + k) % SIZE);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) ptr <= PW'(SIZE - 1);
      else if (update) ptr <= idx;

endmodule

// File: rtl/packet_buffer_reader.sv
// packet_buffer_reader: pops per-PP packet buffer FIFOs round-robin into one slot per PacketPlayer.
module packet_buffer_reader
   import packet_buffer_reader_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [N-1:0]       rd_ready,
   output logic [N-1:0]       rd_select,
   input  logic [WIDTH-1:0]   rd_packet,
   output logic [N-1:0]       pp_valid,
   output logic [N*WIDTH-1:0] pp_packet,
   input  logic [N-1:0]       pp_ack,
   output logic [15:0]        pkt_count
);

   slot_t state [N];
   logic [N-1:0] request, pending;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         request[i]  = enable && rd_ready[i] && state[i] == EMPTY;
         pending[i]  = state[i] == PENDING;
         pp_valid[i] = state[i] == FULL;
      end
   end

   rr_arbiter_N #(.SIZE(N)) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .request (request),
      .update  (|request),
      .grant   (rd_select)
   );

   // buffer data lands one cycle after the pop, so the PENDING slot captures it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) state[i] <= EMPTY;
         pp_packet <= '0;
         pkt_count <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rd_select[i]) state[i] <= PENDING;
            else if (pending[i]) begin
               state[i]                     <= FULL;
               pp_packet[i*WIDTH +: WIDTH] <= rd_packet;
            end else if (state[i] == FULL && pp_ack[i]) state[i] <= EMPTY;
         end
         if (|pending) pkt_count <= pkt_count + 16'd1;
      end
   end

endmodule
